// File: rtl/ntt_twiddle_scheduler_pkg.sv
// ntt_twiddle_scheduler_pkg: shared constants and FSM state type for the Kyber NTT scheduler
package ntt_twiddle_scheduler_pkg;
   localparam int NUM_BU          = 8;
   localparam int N               = 256;
   localparam int LAYERS          = 7;
   localparam int ISSUE_PER_LAYER = 16;
   localparam int WIDTH_ADDR      = 7;
   localparam int WIDTH_CADDR     = 8;
   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
endpackage

// File: rtl/ntt_twiddle_scheduler_if.sv
// ntt_twiddle_scheduler_if: control handshake and per-BU address bus of the NTT scheduler
interface ntt_twiddle_scheduler_if;
   import ntt_twiddle_scheduler_pkg::*;
   logic                                   start_i;
   logic                                   stall_i;
   logic                                   busy_o;
   logic                                   done_o;
   logic                                   valid_o;
   logic [2:0]                             layer_o;
   logic [NUM_BU-1:0][WIDTH_ADDR-1:0]      twid_addr_o;
   logic [NUM_BU-1:0][WIDTH_CADDR-1:0]     coef_a_addr_o;
   logic [NUM_BU-1:0][WIDTH_CADDR-1:0]     coef_b_addr_o;
   modport master (
      input  start_i, stall_i,
      output busy_o, done_o, valid_o, layer_o, twid_addr_o, coef_a_addr_o, coef_b_addr_o
   );
   modport slave (
      output start_i, stall_i,
      input  busy_o, done_o, valid_o, layer_o, twid_addr_o, coef_a_addr_o, coef_b_addr_o
   );
endinterface

// File: rtl/ntt_twiddle_scheduler_bu_addr_gen.sv
// ntt_bu_addr_gen: maps (layer, butterfly index) to twiddle and coefficient pair addresses
module ntt_bu_addr_gen
   import ntt_twiddle_scheduler_pkg::*;
(
   input  logic [2:0]             i_s,
   input  logic [6:0]             i_b,
   output logic [WIDTH_ADDR-1:0]  o_twid,
   output logic [WIDTH_CADDR-1:0] o_coef_a,
   output logic [WIDTH_CADDR-1:0] o_coef_b
);
   logic [6:0] w_g;
   logic [7:0] w_len;
   assign w_g      = i_b >> (3'd7 - i_s);
   assign w_len    = 8'd128 >> i_s;
   assign o_twid   = (7'd1 << i_s) + w_g;
   assign o_coef_a = ({1'b0, w_g} << (4'd8 - {1'b0, i_s})) | ({1'b0, i_b} & (w_len - 8'd1));
   assign o_coef_b = o_coef_a + w_len;
endmodule

// File: rtl/ntt_twiddle_scheduler.sv
// ntt_twiddle_scheduler: sequences the 7-layer forward Kyber NTT over 8 butterfly units
module ntt_twiddle_scheduler
   import ntt_twiddle_scheduler_pkg::*;
#(
   parameter int PIPE_DEPTH = 4
)(
   input logic                      clk_i,
   input logic                      rst_i,
   ntt_twiddle_scheduler_if.master  bus
);
   localparam int DW = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;
   state_t          r_state;
   logic [2:0]      r_layer;
   logic [3:0]      r_cnt;
   logic [DW-1:0]   r_drain;
   logic            r_busy;
   logic            r_done;
   logic [3:0]      w_cnt;
   // outside ISSUE the generators see the last issued slot so drained addresses hold
   assign w_cnt       = (r_state == ISSUE) ? r_cnt : 4'(ISSUE_PER_LAYER - 1);
   assign bus.valid_o = (r_state == ISSUE) && !bus.stall_i;
   assign bus.busy_o  = r_busy;
   assign bus.done_o  = r_done;
   assign bus.layer_o = r_layer;
   for (genvar u = 0; u < NUM_BU; u++) begin : g_bu
      logic [WIDTH_ADDR-1:0]  w_tw;
      logic [WIDTH_CADDR-1:0] w_a;
      logic [WIDTH_CADDR-1:0] w_b;
      ntt_bu_addr_gen u_gen (
         .i_s      (r_layer),
         .i_b      ({w_cnt, 3'(u)}),
         .o_twid   (w_tw),
         .o_coef_a (w_a),
         .o_coef_b (w_b)
      );
      assign bus.twid_addr_o[u]   = (r_state == IDLE) ? '0 : w_tw;
      assign bus.coef_a_addr_o[u] = (r_state == IDLE) ? '0 : w_a;
      assign bus.coef_b_addr_o[u] = (r_state == IDLE) ? '0 : w_b;
   end
   // control FSM: issue 16 slots per layer, drain the pipeline, then pulse done
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         r_state <= IDLE;
         r_layer <= '0;
         r_cnt   <= '0;
         r_drain <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: if (bus.start_i) begin
               r_state <= ISSUE;
               r_layer <= '0;
               r_cnt   <= '0;
               r_busy  <= 1'b1;
            end
            ISSUE: if (!bus.stall_i) begin
               r_cnt   <= (r_cnt == 4'(ISSUE_PER_LAYER - 1)) ? 4'd0 : r_cnt + 4'd1;
               r_drain <= '0;
               if (r_cnt == 4'(ISSUE_PER_LAYER - 1)) r_state <= DRAIN;
            end
            DRAIN: if (!bus.stall_i) begin
               r_drain <= (r_drain == DW'(PIPE_DEPTH - 1)) ? '0 : r_drain + 1'b1;
               if (r_drain == DW'(PIPE_DEPTH - 1)) begin
                  r_state <= (r_layer == 3'(LAYERS - 1)) ? DONE : ISSUE;
                  r_done  <= (r_layer == 3'(LAYERS - 1));
                  r_layer <= (r_layer == 3'(LAYERS - 1)) ? r_layer : r_layer + 3'd1;
               end
            end
            default: begin
               r_state <= IDLE;
               r_layer <= '0;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_ntt_twiddle_scheduler.sv
// tb_ntt_twiddle_scheduler: checks the scheduler against the reference Cooley-Tukey loop order
module tb_ntt_twiddle_scheduler;
   import ntt_twiddle_scheduler_pkg::*;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;
   ntt_twiddle_scheduler_if bus ();
   ntt_twiddle_scheduler #(.PIPE_DEPTH(4)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

   int n_cmp = 0;
   int n_bad = 0;
   int exp_tw[896];
   int exp_a[896];
   int exp_b[896];
   int hist[128];
   int idx, n_valid, n_drain;
   logic [NUM_BU-1:0][WIDTH_ADDR-1:0]  last_tw;
   logic [NUM_BU-1:0][WIDTH_CADDR-1:0] last_a, last_b;

   task automatic check(input string name, input int act, input int req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   // reference forward NTT loop: zeta index k counts blocks, j walks each block
   task automatic build_model();
      int k = 1;
      int p = 0;
      for (int len = 128; len >= 2; len = len / 2)
         for (int st = 0; st < 256; st = st + 2 * len) begin
            for (int j = st; j < st + len; j++) begin
               exp_tw[p] = k;
               exp_a[p]  = j;
               exp_b[p]  = j + len;
               p++;
            end
            k++;
         end
   endtask

   task automatic clear_run();
      idx = 0;
      n_valid = 0;
      n_drain = 0;
      for (int t = 0; t < 128; t++) hist[t] = 0;
   endtask

   task automatic monitor();
      if (rst && bus.valid_o) begin
         if (idx > 888) begin
            n_cmp++;
            n_bad++;
            $display("FAIL overrun: valid issue beyond 896 butterflies, idx %0d", idx);
         end else begin
            int bad = -1;
            for (int u = 0; u < NUM_BU; u++) begin
               if (int'(bus.twid_addr_o[u]) !== exp_tw[idx+u] || int'(bus.coef_a_addr_o[u]) !== exp_a[idx+u] ||
                   int'(bus.coef_b_addr_o[u]) !== exp_b[idx+u]) bad = (bad < 0) ? u : bad;
               hist[bus.twid_addr_o[u]]++;
            end
            n_cmp++;
            if (bad >= 0 || int'(bus.layer_o) !== idx / 128) begin
               n_bad++;
               $display("FAIL issue idx %0d bu %0d: got layer %0d tw %0d a %0d b %0d, expected layer %0d tw %0d a %0d b %0d",
                        idx, (bad < 0) ? 0 : bad, bus.layer_o, bus.twid_addr_o[(bad < 0) ? 0 : bad],
                        bus.coef_a_addr_o[(bad < 0) ? 0 : bad], bus.coef_b_addr_o[(bad < 0) ? 0 : bad],
                        idx / 128, exp_tw[idx+((bad < 0) ? 0 : bad)], exp_a[idx+((bad < 0) ? 0 : bad)],
                        exp_b[idx+((bad < 0) ? 0 : bad)]);
            end
            if (idx == 0)
               for (int u = 0; u < NUM_BU; u++) begin
                  check("l0c0_twid", int'(bus.twid_addr_o[u]), 1);
                  check("l0c0_coef_a", int'(bus.coef_a_addr_o[u]), u);
                  check("l0c0_coef_b", int'(bus.coef_b_addr_o[u]), u + 128);
               end
            if (idx == 400) begin
               check("l3c2_twid", int'(bus.twid_addr_o[0]), 9);
               check("l3c2_coef_a", int'(bus.coef_a_addr_o[0]), 32);
               check("l3c2_coef_b", int'(bus.coef_b_addr_o[0]), 48);
            end
            if (idx == 888) begin
               check("l6c15_twid", int'(bus.twid_addr_o[7]), 127);
               check("l6c15_coef_a", int'(bus.coef_a_addr_o[7]), 253);
               check("l6c15_coef_b", int'(bus.coef_b_addr_o[7]), 255);
            end
         end
         last_tw = bus.twid_addr_o;
         last_a  = bus.coef_a_addr_o;
         last_b  = bus.coef_b_addr_o;
         idx += 8;
         n_valid++;
      end else if (rst && bus.busy_o && !bus.done_o && !bus.stall_i) begin
         n_drain++;
         check("drain_hold", int'(bus.twid_addr_o === last_tw && bus.coef_a_addr_o === last_a &&
                                   bus.coef_b_addr_o === last_b), 1);
      end
   endtask

   // every cycle: sample at the falling edge, then return just after the next rising edge
   task automatic tick();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input string name);
      check({name, "_busy"}, int'(bus.busy_o), 0);
      check({name, "_done"}, int'(bus.done_o), 0);
      check({name, "_valid"}, int'(bus.valid_o), 0);
      check({name, "_layer"}, int'(bus.layer_o), 0);
      check({name, "_addr"}, int'((|bus.twid_addr_o) | (|bus.coef_a_addr_o) | (|bus.coef_b_addr_o)), 0);
   endtask

   task automatic check_hist(input string name);
      int bad_t = 0;
      for (int t = 1; t < 128; t++)
         if (hist[t] != (128 >> ($clog2(t + 1) - 1)) && bad_t == 0) bad_t = t;
      check({name, "_first_bad_twid"}, bad_t, 0);
   endtask

   initial begin
      int e;
      int st_left;
      bit st_done, rp, saw_done;
      bus.start_i = 1'b0;
      bus.stall_i = 1'b0;
      build_model();
      check("model_l0_b7", exp_b[7], 135);
      check("model_l3_twid", exp_tw[400], 9);
      check("model_l3_a", exp_a[400], 32);
      check("model_l3_b", exp_b[400], 48);
      check("model_l6_twid", exp_tw[895], 127);
      check("model_l6_a", exp_a[895], 253);
      check("model_l6_b", exp_b[895], 255);
      clear_run();
      tick();
      tick();
      check_idle("por");
      rst = 1'b1;
      tick();
      check_idle("idle");

      // run 1: no stall
      bus.start_i = 1'b1;
      tick();
      bus.start_i = 1'b0;
      e = 0;
      while (!bus.done_o && e < 400) begin
         tick();
         e++;
      end
      check("run1_done_cycle", e + 1, 141);
      tick();
      check("run1_done_pulse", int'(bus.done_o), 0);
      check("run1_busy_after", int'(bus.busy_o), 0);
      check("run1_valid_cycles", n_valid, 112);
      check("run1_drain_cycles", n_drain, 28);
      check_hist("run1");

      // run 2: 5-cycle stall at layer 2 cnt 7, start re-pulsed while busy and held in DONE
      clear_run();
      st_left = 0;
      st_done = 0;
      rp = 0;
      bus.start_i = 1'b1;
      tick();
      bus.start_i = 1'b0;
      e = 0;
      while (!bus.done_o && e < 400) begin
         tick();
         e++;
         bus.start_i = 1'b0;
         if (st_left > 0) begin
            st_left--;
            if (st_left == 0) bus.stall_i = 1'b0;
         end else if (n_valid == 39 && !st_done) begin
            bus.stall_i = 1'b1;
            st_left = 5;
            st_done = 1;
         end
         if (n_valid == 60 && !rp) begin
            bus.start_i = 1'b1;
            rp = 1;
         end
      end
      check("run2_done_cycle", e + 1, 146);
      bus.start_i = 1'b1;
      tick();
      bus.start_i = 1'b0;
      check("run2_done_pulse", int'(bus.done_o), 0);
      tick();
      check("run2_start_in_done_ignored", int'(bus.busy_o), 0);
      check("run2_valid_cycles", n_valid, 112);
      check("run2_drain_cycles", n_drain, 28);
      check_hist("run2");

      // run 3: reset mid-ISSUE aborts without done
      clear_run();
      bus.start_i = 1'b1;
      tick();
      bus.start_i = 1'b0;
      repeat (10) tick();
      check("run3_busy_before_rst", int'(bus.busy_o), 1);
      rst = 1'b0;
      tick();
      tick();
      check_idle("midrst");
      rst = 1'b1;
      saw_done = 0;
      repeat (150) begin
         tick();
         saw_done |= bus.done_o;
      end
      check("run3_no_done", int'(saw_done), 0);
      check_idle("run3_end");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
